// File: rtl/ctrl_pkg.sv
// Shared types and widths for the ROM arbiter: FSM state, ROM bus widths and
// the round-robin pointer step.
package ctrl_pkg;

  localparam int ROM_AW = 5;
  localparam int ROM_DW = 32;
  localparam int CNT_W  = 4;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int next_idx(input int i, input int n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping modulo N, returned as a one-hot vector (all-zero when nobody asks).
module rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_win
);

  int w_dist;
  int w_best_dist;
  int w_best_idx;

  // NOTE: every variable driven here gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    o_win       = '0;
    w_dist      = 0;
    w_best_dist = N;
    w_best_idx  = 0;
    for (int j = 0; j < N; j++) begin
      w_dist = (j + N - int'(i_ptr)) % N;
      if (i_req[j] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best_idx  = j;
      end
    end
    for (int j = 0; j < N; j++) begin
      o_win[j] = i_req[j] && (j == w_best_idx);
    end
  end

endmodule

// File: rtl/rom_arb.sv
// Round-robin arbiter sharing one instruction ROM among NREQ requesters, with
// bounded burst ownership (lock) and an RD_LAT-deep response tag pipeline.
module rom_arb
  import ctrl_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*ROM_AW-1:0]   req_addr,
  input  logic [NREQ-1:0]          lock,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rsp_vld,
  output logic [ROM_DW-1:0]        rsp_data,
  output logic                     rom_rd,
  output logic [ROM_AW-1:0]        rom_addr,
  input  logic [ROM_DW-1:0]        rom_data
);

  localparam int PW = $clog2(NREQ);

  arb_state_e                  r_state;
  logic [PW-1:0]               r_ptr;
  logic [PW-1:0]               r_owner;
  logic [CNT_W-1:0]            r_cnt;
  logic [NREQ-1:0]             r_blk;
  logic [NREQ-1:0]             r_gnt;
  logic                        r_rom_rd;
  logic [ROM_AW-1:0]           r_rom_addr;
  logic [RD_LAT-1:0][NREQ-1:0] r_tag;
  logic [NREQ-1:0]             r_rsp_vld;
  logic [ROM_DW-1:0]           r_rsp_data;

  logic [NREQ-1:0]   w_owner_oh;
  logic              w_owner_lock;
  logic [NREQ-1:0]   w_elig;
  logic [NREQ-1:0]   w_win;
  logic              w_win_any;
  logic              w_win_lock;
  logic [PW-1:0]     w_win_idx;
  logic [PW-1:0]     w_next_ptr;
  logic [ROM_AW-1:0] w_win_addr;
  logic              w_cnt_last;
  logic [NREQ-1:0]   w_blk_kept;

  // A requester whose gnt is high this cycle sits out; in LOCKED only the owner may win,
  // and a dropped owner lock yields no grant so others compete from ARB next cycle.
  always_comb begin
    w_owner_oh   = NREQ'(1) << r_owner;
    w_owner_lock = |(lock & w_owner_oh);
    w_elig       = req & ~r_gnt;
    if (r_state == LOCKED) begin
      w_elig = w_owner_lock ? (w_elig & w_owner_oh) : '0;
    end
  end

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_rr_pick (
    .i_req (w_elig),
    .i_ptr (r_ptr),
    .o_win (w_win)
  );

  always_comb begin
    w_win_any  = |w_win;
    w_win_lock = |(w_win & lock & ~r_blk);
    w_win_idx  = '0;
    w_next_ptr = '0;
    w_win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) begin
        w_win_idx  = PW'(i);
        w_next_ptr = PW'(next_idx(i, NREQ));
        w_win_addr = req_addr[i*ROM_AW +: ROM_AW];
      end
    end
    w_cnt_last = (r_cnt == CNT_W'(LOCK_MAX - 1));
    w_blk_kept = r_blk & lock;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values and later statements may safely override earlier ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= ARB;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_blk      <= '0;
      r_gnt      <= '0;
      r_rom_rd   <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_gnt    <= w_win;
      r_rom_rd <= w_win_any;
      r_blk    <= w_blk_kept;
      if (w_win_any) begin
        r_rom_addr <= w_win_addr;
        r_ptr      <= w_next_ptr;
      end
      case (r_state)
        ARB: begin
          if (w_win_any && w_win_lock) begin
            if (LOCK_MAX == 1) begin
              r_blk <= w_blk_kept | w_win;
            end else begin
              r_state <= LOCKED;
              r_owner <= w_win_idx;
              r_cnt   <= CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          // The pointer already sits at owner+1 from the owner's last grant.
          if (!w_owner_lock) begin
            r_state <= ARB;
            r_cnt   <= '0;
          end else if (w_win_any) begin
            if (w_cnt_last) begin
              r_state <= ARB;
              r_cnt   <= '0;
              r_blk   <= w_blk_kept | w_win;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  // NOTE: the tag pipeline is reset (unlike a data memory) so grants issued before reset can never surface as responses afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tag      <= '0;
      r_rsp_vld  <= '0;
      r_rsp_data <= '0;
    end else begin
      r_tag[0] <= r_gnt;
      for (int s = 1; s < RD_LAT; s++) begin
        r_tag[s] <= r_tag[s-1];
      end
      r_rsp_vld <= r_tag[RD_LAT-1];
      if (|r_tag[RD_LAT-1]) begin
        r_rsp_data <= rom_data;
      end
    end
  end

  assign gnt      = r_gnt;
  assign rom_rd   = r_rom_rd;
  assign rom_addr = r_rom_addr;
  assign rsp_vld  = r_rsp_vld;
  assign rsp_data = r_rsp_data;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_rd_vs_gnt:  assert property (@(posedge clk) disable iff (!rst) rom_rd == (|gnt));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(rsp_vld));

endmodule

// File: doc/rom_arb.md
ROM_ARB -- requirements
Module: rom_arb

Interface
REQ-001 SHALL have parameter NREQ, default 2, number of requesters (legal 2..4).
REQ-002 SHALL have parameter RD_LAT, default 1, ROM read latency in cycles from rom_rd to rom_data valid (legal 1..2).
REQ-003 SHALL have parameter LOCK_MAX, default 8, maximum consecutive grants to one locked owner (legal 1..15).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-006 SHALL have port req  in  NREQ  per-requester read request, level, held until gnt seen.
REQ-007 SHALL have port req_addr  in  NREQ*5  per-requester ROM address; slice i = bits 5i+4:5i.
REQ-008 SHALL have port lock  in  NREQ  per-requester lock request (burst ownership).
REQ-009 SHALL have port gnt  out  NREQ  one-hot, one-cycle pulse: request accepted this cycle.
REQ-010 SHALL have port rsp_vld  out  NREQ  one-hot, one-cycle pulse: rsp_data belongs to that requester.
REQ-011 SHALL have port rsp_data  out  32  registered ROM word.
REQ-012 SHALL have ports rom_rd  out  1, rom_addr  out  5, rom_data  in  32, driving the single shared instruction ROM.

Function
REQ-013 SHALL arbitrate in cycle T over eligible requesters; the winner's gnt, rom_rd=1 and rom_addr=its req_addr SHALL be registered outputs in cycle T+1.
REQ-014 SHALL issue at most one grant per cycle; gnt, rom_rd and the winner index SHALL always be consistent.
REQ-015 SHALL mask a requester from arbitration in the cycle its gnt is high (no back-to-back grant to the same requester).
REQ-016 SHALL use round-robin priority: pointer starts at requester 0 and, after each grant to i, moves to (i+1) mod NREQ; pointer unchanged when no grant.
REQ-017 SHALL, with no eligible request, assert no gnt and rom_rd=0; rom_addr SHALL hold its last value.
REQ-018 SHALL track each grant through an RD_LAT-deep tag pipeline; rom_rd in cycle T SHALL produce rsp_vld for that requester and rsp_data = rom_data(T+RD_LAT) in cycle T+RD_LAT+1.
REQ-019 SHALL hold rsp_data when rsp_vld is all-zero.
REQ-020 SHALL implement FSM states ARB and LOCKED.
REQ-021 ARB->LOCKED SHALL occur when a grant is issued to requester i with lock[i]=1 in the arbitration cycle; i becomes owner, grant counter set to 1.
REQ-022 In LOCKED only the owner SHALL be eligible; lock from non-owners SHALL be ignored; each owner grant increments the counter.
REQ-023 LOCKED->ARB SHALL occur when owner lock=0 (sampled) or counter reaches LOCK_MAX; pointer SHALL then be owner+1.
REQ-024 After a LOCK_MAX forced release, the owner's lock SHALL be ignored until it deasserts lock for at least one cycle.
REQ-025 Owner holding lock with req=0 SHALL keep LOCKED with no grants (counter unchanged).
REQ-026 Simultaneous lock drop and new requests from others SHALL be arbitrated in ARB in the following cycle.

Reset
REQ-027 While rst=0: gnt=0, rsp_vld=0, rom_rd=0, rom_addr=0, rsp_data=0, pointer=0, state ARB, counter=0, tag pipeline cleared, release-block flags cleared.
REQ-028 Reset mid-transfer SHALL discard in-flight responses; no rsp_vld SHALL appear for grants issued before reset.

Structure
REQ-029 State enum (ARB, LOCKED), ROM address width 5 and data width 32 SHALL live in shared package ctrl_pkg.
REQ-030 Round-robin pick (request vector + pointer -> one-hot winner) SHALL be sub-module rr_pick, purely combinational.

Verification
REQ-031 Only req[0]=1, addr 3, RD_LAT=1 -> gnt[0] T+1, rom_rd with addr 3, rsp_vld[0] T+3 with ROM word 3; repeat every second cycle while req held.
REQ-032 req=2'b11 held, pointer 0 -> grants alternate 0,1,0,1; each rsp_vld carries its own address's data.
REQ-033 req[1]=1, lock[1]=1, req[0]=1, LOCK_MAX=4 -> 4 grants to 1 only (every other cycle), then forced ARB, next grant to 0.
REQ-034 LOCKED owner 1 drops lock while req[0]=1 -> next grant goes to 0 within 2 cycles.
REQ-035 RD_LAT=2, alternating grants -> rsp_vld at T+3, order and data match grant order.
REQ-036 rst=0 one cycle after a grant -> no rsp_vld afterwards, all outputs 0, first post-reset grant to requester 0.
